// File: rtl/gpsdo_pkg.sv
// Shared GPSDO types and constants: phase-detector state encoding, datapath widths,
// and default loop constants also used by the loop-filter block.
package gpsdo_pkg;

    localparam int unsigned PHASE_W         = 25;
    localparam int unsigned CNT_W           = 24;
    localparam int unsigned LOCK_CNT_W      = 8;
    localparam int unsigned DEF_WINDOW      = 5_000_000;
    localparam int unsigned DEF_LOCK_THRESH = 100;
    localparam int unsigned DEF_LOCK_NUM    = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_GPS_FIRST = 2'd2,
        ST_LOC_FIRST = 2'd3
    } meas_state_e;

    // Magnitude of a phase result; the measurement window keeps it clear of -2^24.
    function automatic logic [PHASE_W-1:0] phase_abs(input logic signed [PHASE_W-1:0] d);
        return d[PHASE_W-1] ? PHASE_W'(-d) : PHASE_W'(d);
    endfunction

endpackage

// File: rtl/pps_lock_det.sv
// Lock qualifier: counts consecutive in-threshold phase results and flags lock
// once LOCK_NUM of them have been seen; any bad result, timeout or disable clears it.
module pps_lock_det
    import gpsdo_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = DEF_LOCK_THRESH,
    parameter int unsigned LOCK_NUM    = DEF_LOCK_NUM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic                      i_valid,
    input  logic                      i_timeout,
    input  logic signed [PHASE_W-1:0] i_diff,
    output logic                      o_locked
);

    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_next;
    logic                  w_in_lock;

    assign w_in_lock = (phase_abs(i_diff) <= PHASE_W'(LOCK_THRESH));

    always_comb begin
        w_lock_cnt_next = r_lock_cnt;
        if (!i_en || i_timeout) begin
            w_lock_cnt_next = '0;
        end else if (i_valid) begin
            if (!w_in_lock) begin
                w_lock_cnt_next = '0;
            end else if (r_lock_cnt != LOCK_CNT_W'(LOCK_NUM)) begin
                w_lock_cnt_next = r_lock_cnt + LOCK_CNT_W'(1);
            end
        end
    end

    // Locked follows the updated count so it moves the cycle after the qualifying result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
            o_locked   <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_cnt_next;
            o_locked   <= (w_lock_cnt_next == LOCK_CNT_W'(LOCK_NUM));
        end
    end

endmodule

// File: rtl/pps_phase_meas.sv
// 1PPS phase detector: signed tick count between the GPS and local 1PPS rising edges,
// one result per second, with window timeout and lock indication.
module pps_phase_meas
    import gpsdo_pkg::*;
#(
    parameter int unsigned                 WINDOW      = DEF_WINDOW,
    parameter logic signed [PHASE_W-1:0]   CAL_OFFSET  = '0,
    parameter int unsigned                 LOCK_THRESH = DEF_LOCK_THRESH,
    parameter int unsigned                 LOCK_NUM    = DEF_LOCK_NUM
) (
    input  logic                      CLK_SYS,
    input  logic                      CLK_RST,
    input  logic                      Meas_EN,
    input  logic                      Flag_GPS_posedge,
    input  logic                      _1PPS_Local,
    output logic signed [PHASE_W-1:0] Phase_Diff,
    output logic                      Phase_Valid,
    output logic                      Phase_Timeout,
    output logic                      Locked
);

    meas_state_e               r_state;
    meas_state_e               w_state_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_next;
    logic                      r_local_d;
    logic                      w_loc_rise;
    logic                      w_gps_rise;
    logic                      w_emit;
    logic                      w_timeout;
    logic                      w_at_window;
    logic [PHASE_W-1:0]        w_cnt_inc;
    logic signed [PHASE_W-1:0] w_raw;

    assign w_loc_rise  = _1PPS_Local & ~r_local_d;
    assign w_gps_rise  = Flag_GPS_posedge;
    assign w_cnt_inc   = PHASE_W'(r_cnt) + PHASE_W'(1);
    assign w_at_window = (w_cnt_inc == PHASE_W'(WINDOW));

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A closing edge beats both the restart and the window timeout.
    always_comb begin
        w_state_next = r_state;
        if (!Meas_EN) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = ST_WAIT;
                ST_WAIT: begin
                    if (w_gps_rise && !w_loc_rise) begin
                        w_state_next = ST_GPS_FIRST;
                    end else if (w_loc_rise && !w_gps_rise) begin
                        w_state_next = ST_LOC_FIRST;
                    end
                end
                ST_GPS_FIRST: begin
                    if (w_loc_rise || (!w_gps_rise && w_at_window)) begin
                        w_state_next = ST_WAIT;
                    end
                end
                ST_LOC_FIRST: begin
                    if (w_gps_rise || (!w_loc_rise && w_at_window)) begin
                        w_state_next = ST_WAIT;
                    end
                end
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_emit     = 1'b0;
        w_timeout  = 1'b0;
        w_raw      = '0;
        w_cnt_next = r_cnt;
        if (!Meas_EN) begin
            w_cnt_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_cnt_next = '0;
                ST_WAIT: begin
                    w_cnt_next = '0;
                    w_emit     = w_gps_rise & w_loc_rise;
                end
                ST_GPS_FIRST: begin
                    w_cnt_next = CNT_W'(w_cnt_inc);
                    if (w_loc_rise) begin
                        w_emit     = 1'b1;
                        w_raw      = $signed(w_cnt_inc);
                        w_cnt_next = '0;
                    end else if (w_gps_rise) begin
                        w_cnt_next = '0;
                    end else if (w_at_window) begin
                        w_timeout  = 1'b1;
                        w_cnt_next = '0;
                    end
                end
                ST_LOC_FIRST: begin
                    w_cnt_next = CNT_W'(w_cnt_inc);
                    if (w_gps_rise) begin
                        w_emit     = 1'b1;
                        w_raw      = -$signed(w_cnt_inc);
                        w_cnt_next = '0;
                    end else if (w_loc_rise) begin
                        w_cnt_next = '0;
                    end else if (w_at_window) begin
                        w_timeout  = 1'b1;
                        w_cnt_next = '0;
                    end
                end
                default: w_cnt_next = '0;
            endcase
        end
    end

    // Phase_Diff only moves on a result so the loop filter can read it at leisure.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_cnt         <= '0;
            r_local_d     <= 1'b0;
            Phase_Diff    <= '0;
            Phase_Valid   <= 1'b0;
            Phase_Timeout <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_local_d     <= _1PPS_Local;
            Phase_Valid   <= w_emit;
            Phase_Timeout <= w_timeout;
            if (w_emit) begin
                Phase_Diff <= w_raw + CAL_OFFSET;
            end
        end
    end

    pps_lock_det #(
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_NUM    (LOCK_NUM)
    ) u_lock_det (
        .clk       (CLK_SYS),
        .rst_n     (CLK_RST),
        .i_en      (Meas_EN),
        .i_valid   (Phase_Valid),
        .i_timeout (Phase_Timeout),
        .i_diff    (Phase_Diff),
        .o_locked  (Locked)
    );

endmodule
